// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: boundary-mode encoding and a
// constant ceil-log2 used to size the prescaler phase register.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Smallest width able to hold value-1; never less than 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one.
// With PRESCALE=1 the tick is constantly high and no state is built.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, nrst, en, sclr};
            assign tick = 1'b1;
        end else begin : g_divide
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0] ONE  = PW'(1);

            logic [PW-1:0] phase;

            // Phase holds while en is low; it only restarts on tick, clear or reset.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    phase <= '0;
                end else if (sclr) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= tick ? '0 : phase + ONE;
                end
            end

            assign tick = (phase == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate boundaries, parallel load,
// synchronous clear, enable prescaler, and sticky overflow/underflow flags.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             control,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_p,
    output logic             ovf,
    output logic             udf
);

    // MODULO-1 is formed in int first so MODULO = 2**WIDTH yields all ones.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam bit SAT_MODE = (SATURATE == int'(MODE_SAT));

    logic tick;
    logic step;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .nrst (nrst),
        .en   (en),
        .sclr (clr | load),
        .tick (tick)
    );

    assign step   = en & tick;
    assign at_max = (count == MAX);
    assign at_min = (count == '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count  <= '0;
            wrap_p <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wrap_p <= 1'b0;
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
                udf   <= 1'b0;
            end else if (load) begin
                count <= (load_val > MAX) ? MAX : load_val;
            end else if (step) begin
                if (control) begin
                    if (!at_max) begin
                        count <= count + ONE;
                    end else begin
                        ovf <= 1'b1;
                        if (!SAT_MODE) begin
                            count  <= '0;
                            wrap_p <= 1'b1;
                        end
                    end
                end else begin
                    if (!at_min) begin
                        count <= count - ONE;
                    end else begin
                        udf <= 1'b1;
                        if (!SAT_MODE) begin
                            count  <= MAX;
                            wrap_p <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: four configurations share one stimulus stream
// and are compared against an arithmetic reference model every cycle.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       control = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] cnt [4];
    logic       wrp [4];
    logic       ovf_o [4];
    logic       udf_o [4];
    logic       amax [4];
    logic       amin [4];

    // 0: mod10 wrap, 1: mod10 saturate, 2: mod10 wrap prescale 3, 3: mod16 wrap
    int modv [4] = '{10, 10, 10, 16};
    int psv  [4] = '{1, 1, 3, 1};
    bit satv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    int mc [4];
    int mn [4];
    bit mw [4];
    bit mo [4];
    bit mu [4];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) dut_wrap (
        .clk(clk), .nrst(nrst), .en(en), .control(control), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
        .wrap_p(wrp[0]), .ovf(ovf_o[0]), .udf(udf_o[0]));

    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) dut_sat (
        .clk(clk), .nrst(nrst), .en(en), .control(control), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
        .wrap_p(wrp[1]), .ovf(ovf_o[1]), .udf(udf_o[1]));

    updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
        .clk(clk), .nrst(nrst), .en(en), .control(control), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt[2]), .at_max(amax[2]), .at_min(amin[2]),
        .wrap_p(wrp[2]), .ovf(ovf_o[2]), .udf(udf_o[2]));

    updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(1)) dut_full (
        .clk(clk), .nrst(nrst), .en(en), .control(control), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt[3]), .at_max(amax[3]), .at_min(amin[3]),
        .wrap_p(wrp[3]), .ovf(ovf_o[3]), .udf(udf_o[3]));

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mc[k] = 0; mn[k] = 0; mw[k] = 1'b0; mo[k] = 1'b0; mu[k] = 1'b0;
        end
    endfunction

    // One rising edge of behaviour, straight from the counting rules.
    function automatic void model_edge();
        if (!nrst) return;
        for (int k = 0; k < 4; k++) begin
            mw[k] = 1'b0;
            if (clr) begin
                mc[k] = 0; mo[k] = 1'b0; mu[k] = 1'b0; mn[k] = 0;
            end else if (load) begin
                mc[k] = (int'(load_val) >= modv[k]) ? modv[k] - 1 : int'(load_val);
                mn[k] = 0;
            end else if (en) begin
                mn[k] = mn[k] + 1;
                if (mn[k] == psv[k]) begin
                    mn[k] = 0;
                    if (control) begin
                        if (mc[k] + 1 < modv[k]) mc[k] = mc[k] + 1;
                        else begin
                            mo[k] = 1'b1;
                            if (!satv[k]) begin mc[k] = 0; mw[k] = 1'b1; end
                        end
                    end else begin
                        if (mc[k] > 0) mc[k] = mc[k] - 1;
                        else begin
                            mu[k] = 1'b1;
                            if (!satv[k]) begin mc[k] = modv[k] - 1; mw[k] = 1'b1; end
                        end
                    end
                end
            end
        end
    endfunction

    // Field order: count[8:5] wrap_p ovf udf at_max at_min
    function automatic logic [8:0] exp_vec(input int k);
        return {4'(mc[k]), mw[k], mo[k], mu[k], (mc[k] == modv[k] - 1), (mc[k] == 0)};
    endfunction

    function automatic logic [8:0] obs_vec(input int k);
        return {cnt[k], wrp[k], ovf_o[k], udf_o[k], amax[k], amin[k]};
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic cl, input logic ld,
                         input logic [3:0] lv);
        en = e; control = c; clr = cl; load = ld; load_val = lv;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL reset dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        step_cycle();
        nrst = 1'b1;
    endtask

    task automatic test_wrap_up();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            step_cycle();
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL wrap_up dut%0d edge%0d: got %b need %b", k, i, obs_vec(k), exp_vec(k));
                else passed++;
            end
            total++;
            if ({cnt[0], wrp[0], amax[0]} !== {4'(i % 10), (i == 10), (i == 9)})
                $display("FAIL wrap_up_seq edge%0d: got cnt=%0d wrap=%b max=%b", i, cnt[0], wrp[0], amax[0]);
            else passed++;
        end
        total++;
        if (ovf_o[0] !== 1'b1) $display("FAIL wrap_up_ovf: got %b need 1", ovf_o[0]);
        else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL underflow dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        total++;
        if ({cnt[0], wrp[0], udf_o[0], cnt[1], wrp[1], udf_o[1]} !== {4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1})
            $display("FAIL underflow_modes: got wrap-dut cnt=%0d w=%b u=%b sat-dut cnt=%0d w=%b u=%b need 9/1/1 0/0/1",
                     cnt[0], wrp[0], udf_o[0], cnt[1], wrp[1], udf_o[1]);
        else passed++;
        step_cycle();
        total++;
        if (wrp[0] !== 1'b0) $display("FAIL underflow_pulse_len: got %b need 0", wrp[0]);
        else passed++;
    endtask

    task automatic test_load_clear();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
        step_cycle();
        total++;
        if ({cnt[0], cnt[3]} !== {4'd9, 4'd13})
            $display("FAIL load_clamp: got %0d/%0d need 9/13", cnt[0], cnt[3]);
        else passed++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        step_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        step_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL load_clear dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        total++;
        if ({cnt[0], ovf_o[0], udf_o[0]} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL clr_priority: got cnt=%0d ovf=%b udf=%b need 0/0/0", cnt[0], ovf_o[0], udf_o[0]);
        else passed++;
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        step_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        step_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        total++;
        if ({cnt[0], ovf_o[0]} !== {4'd7, 1'b1})
            $display("FAIL async_setup: got cnt=%0d ovf=%b need 7/1", cnt[0], ovf_o[0]);
        else passed++;
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL async_reset dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        nrst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            step_cycle();
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL async_restart dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
                else passed++;
            end
        end
        total++;
        if (cnt[0] !== 4'd2) $display("FAIL async_restart_count: got %0d need 2", cnt[0]);
        else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_prescaler();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step_cycle();
        step_cycle();
        total++;
        if (cnt[2] !== 4'd0) $display("FAIL prescale_early: got %0d need 0", cnt[2]);
        else passed++;
        en = 1'b0;
        repeat (4) step_cycle();
        en = 1'b1;
        step_cycle();
        total++;
        if (cnt[2] !== 4'd1) $display("FAIL prescale_resume: got %0d need 1", cnt[2]);
        else passed++;
        for (int i = 1; i <= 6; i++) begin
            step_cycle();
            total++;
            if (obs_vec(2) !== exp_vec(2))
                $display("FAIL prescale_run edge%0d: got %b need %b", i, obs_vec(2), exp_vec(2));
            else passed++;
        end
        total++;
        if (cnt[2] !== 4'd3) $display("FAIL prescale_rate: got %0d need 3", cnt[2]);
        else passed++;
        en = 1'b0;
    endtask

    task automatic test_direction_flip();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
        step_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_vec(k) !== exp_vec(k))
                $display("FAIL dir_flip dut%0d: got %b need %b", k, obs_vec(k), exp_vec(k));
            else passed++;
        end
        total++;
        if ({cnt[0], wrp[0]} !== {4'd8, 1'b0})
            $display("FAIL dir_flip_value: got cnt=%0d wrap=%b need 8/0", cnt[0], wrp[0]);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 11) == 0), 4'($urandom));
            if (i % 97 == 50) begin
                nrst = 1'b0;
                model_reset();
                #2;
                nrst = 1'b1;
            end
            step_cycle();
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k))
                    $display("FAIL random dut%0d cyc%0d: got %b need %b", k, i, obs_vec(k), exp_vec(k));
                else passed++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_underflow();
        test_load_clear();
        test_async_reset();
        test_prescaler();
        test_direction_flip();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, need completion before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter: the next-generation general counter for the DFF/counter library. It adds configurable width and modulus, wrap or saturate mode, parallel load, synchronous clear and an enable prescaler, plus terminal-count and sticky overflow/underflow flags. It sits wherever a 4-bit up/down counter was used, and also serves as a timebase or event counter driving downstream FSMs.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..16.
- `MODULO`, default 16: count range 0..MODULO-1; legal range 2 ≤ MODULO ≤ 2**WIDTH.
- `SATURATE`, default 0: 0 means wrap at the boundaries; 1 means hold at the boundaries.
- `PRESCALE`, default 1: the count advances once per PRESCALE enabled cycles; legal range 1..256.
- `clk` (in, 1): single clock. All state updates on the rising edge.
- `nrst` (in, 1): asynchronous, active-low reset.
- `en` (in, 1): count enable. It gates the prescaler.
- `control` (in, 1): direction. 1 counts up; 0 counts down.
- `clr` (in, 1): synchronous clear.
- `load` (in, 1): synchronous parallel load.
- `load_val` (in, WIDTH): value for `load`.
- `count` (out, WIDTH): current count.
- `at_max` (out, 1): combinational, `count == MODULO-1`.
- `at_min` (out, 1): combinational, `count == 0`.
- `wrap_p` (out, 1): registered one-cycle pulse on an actual wrap.
- `ovf` (out, 1): sticky flag; an up-step was attempted at MODULO-1.
- `udf` (out, 1): sticky flag; a down-step was attempted at 0.

## Operation
**Reset.** While `nrst` is low, asynchronously force: `count`=0, `wrap_p`=0, `ovf`=0, `udf`=0, prescaler phase=0.

**Priority per edge** (highest first): `clr` > `load` > step.
- `clr`: `count`←0, `ovf`←0, `udf`←0, `wrap_p`←0, prescaler phase←0.
- `load`:
  - `count`←`load_val`, clamped to MODULO-1 if `load_val` ≥ MODULO.
  - Prescaler phase←0. Flags unchanged. `wrap_p`←0.

**Step.**
- A step occurs when `en`=1 and the prescaler tick is high. The tick is high on the PRESCALE-th consecutive enabled cycle.
- `en`=0 freezes the prescaler phase; it does not reset it.

**Up step** (`control`=1):
- If `count` < MODULO-1: `count`+1.
- Else, WRAP mode: `count`←0, `wrap_p`←1, `ovf`←1.
- Else, SAT mode: hold, `ovf`←1, `wrap_p` stays 0.

**Down step** (`control`=0):
- If `count` > 0: `count`-1.
- Else, WRAP mode: `count`←MODULO-1, `wrap_p`←1, `udf`←1.
- Else, SAT mode: hold, `udf`←1.

**Idle edges.** `wrap_p` is 0 on every edge where no wrap occurs.

**Direction.** `control` may change on any cycle; it is sampled only on step edges. There is no hysteresis.

**Arithmetic.** All comparisons are unsigned at WIDTH bits. When MODULO=2**WIDTH, MODULO-1 is all ones, and the wrap compare must not overflow the constant width.

## Timing
- `count`, `wrap_p`, `ovf` and `udf` are registered. Their latency is 1 clock from the sampled inputs.
- `at_max` and `at_min` are combinational from `count`. They are valid in the same cycle `count` changes.
- `wrap_p` is high for exactly the cycle in which `count` shows the post-wrap value.
- Asynchronous reset assertion takes effect with no clock. Deassertion is synchronised externally; the block requires no recovery cycle.
- If reset asserts mid-prescale, the next step requires a full PRESCALE enabled cycles after release.
- When `clr`/`load` and a step coincide, `clr`/`load` wins, and the step is dropped (not deferred).

## Structure
- Shared package/header `counter_pkg`:
  - `MODE_WRAP`=0, `MODE_SAT`=1.
  - A `clog2` constant function used for the prescaler width.
- Sub-module `tick_prescaler`:
  - Parameter `PRESCALE`.
  - Ports `clk`, `nrst`, `en`, `sclr`, `tick`.
  - Counts 0..PRESCALE-1 on enabled cycles; `tick` is combinational at PRESCALE-1.
  - `sclr` is driven by `clr|load`.
  - PRESCALE=1 degenerates to `tick`=1 with no flops.
- The top block holds the count register, boundary compare, mode mux and flag logic.

## Test plan
All scenarios use WIDTH=4, MODULO=10, PRESCALE=1 unless stated otherwise.
1. **Wrap up.** Reset, then `en`=1, `control`=1 for 10 edges. Required: `count` goes 1..9 then 0. `wrap_p` is high only in the cycle `count`=0. `ovf`=1. `at_max` is high while `count`=9.
2. **Underflow.** From 0, `control`=0, one step.
   - SATURATE=0: `count`=9, `wrap_p` pulses, `udf`=1.
   - SATURATE=1: `count` stays 0, `wrap_p`=0, `udf`=1.
3. **Load and clear priority.**
   - `load_val`=13 with `load` → `count`=9.
   - `load`=1 and `clr`=1 together while `count`=5 → `count`=0, `ovf`/`udf` cleared.
4. **Async reset mid-count.** At `count`=7 with `ovf`=1, pulse `nrst` low between edges. Required: `count`=0 and `ovf`=0 before the next edge, and counting restarts from 0.
5. **Prescaler.** PRESCALE=3, `en`=1. Required: `count` increments on every 3rd edge.
   - Drop `en` for 4 cycles after the 2nd enabled cycle; `count` must step on the 1st enabled edge after `en` returns.
6. **Direction flip at boundary.** At `count`=9, set `control`=0 and step. Required: `count`=8, `wrap_p`=0, `ovf` unchanged.
